// File: rtl/led_pwm_driver.sv
// led_pwm_driver: output stage between the SoC LED register and the LED pads.
// Each LED bit is gated by a per-channel PWM duty and registered for the pads.
// Duty writes land in a pending bank and are copied to the active bank only at
// the PWM period boundary, so a period always runs with one consistent duty.
//
// Optional build macro: LED_PWM_GAMMA_EN
//   defined   - compare uses g = (duty*duty) >> PWM_BITS, registered at commit
//   undefined - compare uses the raw active duty
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   led_in       raw LED enables from the SoC
//   wr_en        duty write strobe (one cycle)
//   wr_addr      channel index for the write (out-of-range writes are dropped)
//   wr_data      duty value for the write
//   wr_ack       one-cycle pulse acknowledging each write
//   period_start one-cycle pulse on the first clk of each PWM period
//   led_out      registered drive to the output buffers
module led_pwm_driver #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESCALE = 16
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic [NUM_LEDS-1:0]                               led_in,
    input  logic                                              wr_en,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] wr_addr,
    input  logic [PWM_BITS-1:0]                               wr_data,
    output logic                                              wr_ack,
    output logic                                              period_start,
    output logic [NUM_LEDS-1:0]                               led_out
);

    localparam int unsigned AW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PW2  = 2 * PWM_BITS;
    localparam logic [PWM_BITS-1:0] ONES = '1;

    // Prescaler and PWM counter
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                tick;
    logic                wrap;

    // Duty banks
    logic [PWM_BITS-1:0] pend_q [NUM_LEDS];
    logic [PWM_BITS-1:0] pend_d [NUM_LEDS];
    logic [PWM_BITS-1:0] act_q  [NUM_LEDS];
    logic [PWM_BITS-1:0] act_d  [NUM_LEDS];
    logic [PWM_BITS-1:0] thr    [NUM_LEDS];
    logic                addr_ok;

    // Output registers
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] on;
    logic                ack_q;
    logic                ps_q;

`ifdef LED_PWM_GAMMA_EN
    // Full 2*PWM_BITS product kept before dropping the low half
    function automatic logic [PWM_BITS-1:0] gamma_of(input logic [PWM_BITS-1:0] d);
        logic [PW2-1:0] p;
        p = PW2'(d) * PW2'(d);
        return p[PW2-1:PWM_BITS];
    endfunction

    localparam logic [PWM_BITS-1:0] GAM_ONES = gamma_of(ONES);

    logic [PWM_BITS-1:0] gam_q [NUM_LEDS];
    logic [PWM_BITS-1:0] gam_d [NUM_LEDS];
`endif

    // Timebase: prescaler tick and period wrap
    always_comb begin
        tick    = (presc_q == PS_W'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        cnt_d   = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
        wrap    = tick && (cnt_q == ONES);
    end

    // Duty banks: commit reads pending before this edge's write lands
    always_comb begin
        pend_d  = pend_q;
        act_d   = act_q;
        addr_ok = ({1'b0, wr_addr} < (AW + 1)'(NUM_LEDS));
        if (wrap) begin
            act_d = pend_q;
        end
        if (wr_en && addr_ok) begin
            pend_d[wr_addr] = wr_data;
        end
    end

`ifdef LED_PWM_GAMMA_EN
    // Gamma threshold computed once per commit
    always_comb begin
        gam_d = gam_q;
        if (wrap) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                gam_d[i] = gamma_of(pend_q[i]);
            end
        end
    end
`endif

    // Per-channel compare; all-ones duty overrides to always on
    always_comb begin
        thr = act_q;
`ifdef LED_PWM_GAMMA_EN
        thr = gam_q;
`endif
        on = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            on[i] = (act_q[i] == ONES) || (cnt_q < thr[i]);
        end
        led_d = led_in & on;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            ack_q   <= 1'b0;
            ps_q    <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                pend_q[i] <= ONES;
                act_q[i]  <= ONES;
            end
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            ack_q   <= wr_en;
            ps_q    <= wrap;
            pend_q  <= pend_d;
            act_q   <= act_d;
        end
    end

`ifdef LED_PWM_GAMMA_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                gam_q[i] <= GAM_ONES;
            end
        end else begin
            gam_q <= gam_d;
        end
    end
`endif

    assign led_out      = led_q;
    assign wr_ack       = ack_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver. Stimulus is applied on the falling
// edge; for every rising edge the reference model pushes the expected
// {led_out, wr_ack, period_start}, and the monitor pops and compares 1ns after
// the rising edge. The model works from an elapsed-cycle count since reset.
module tb_led_pwm_driver;

    localparam int unsigned NL     = 6;
    localparam int unsigned PB     = 8;
    localparam int unsigned PS     = 2;
    localparam int unsigned AW     = 3;
    localparam int          STEPS  = 256;
    localparam int          PERIOD = PS * STEPS;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NL-1:0] led_in = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PB-1:0] wr_data = '0;
    logic          wr_ack;
    logic          period_start;
    logic [NL-1:0] led_out;

    led_pwm_driver #(
        .NUM_LEDS (NL),
        .PWM_BITS (PB),
        .PRESCALE (PS)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .led_in       (led_in),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .period_start (period_start),
        .led_out      (led_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] led;
        logic          ack;
        logic          ps;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int pend[NL];
    int act[NL];
    int t;

    function automatic int thr_of(input int d);
`ifdef LED_PWM_GAMMA_EN
        return (d * d) / STEPS;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < NL; i++) begin
            pend[i] = STEPS - 1;
            act[i]  = STEPS - 1;
        end
        sb.delete();
    endtask

    // Expected outputs after the coming rising edge, then advance the model
    task automatic model_push();
        exp_t e;
        int   pos;
        bit   wrap;
        pos  = (t / PS) % STEPS;
        wrap = (t % PERIOD) == PERIOD - 1;
        for (int i = 0; i < NL; i++) begin
            e.led[i] = led_in[i] && ((act[i] == STEPS - 1) || (pos < thr_of(act[i])));
        end
        e.ack = wr_en;
        e.ps  = wrap;
        sb.push_back(e);
        if (wrap) begin
            for (int i = 0; i < NL; i++) act[i] = pend[i];
        end
        if (wr_en && int'(wr_addr) < NL) pend[int'(wr_addr)] = int'(wr_data);
        t++;
    endtask

    task automatic drive(input logic [NL-1:0] li, input logic we,
                         input logic [AW-1:0] wa, input logic [PB-1:0] wd);
        led_in  = li;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        model_push();
    endtask

    task automatic step(input logic [NL-1:0] li, input logic we,
                        input logic [AW-1:0] wa, input logic [PB-1:0] wd);
        @(negedge clk);
        drive(li, we, wa, wd);
    endtask

    task automatic idle(input int n, input logic [NL-1:0] li);
        for (int i = 0; i < n; i++) step(li, 1'b0, '0, '0);
    endtask

    // Asynchronous reset pulse, asserted mid-low-phase after the last drive
    task automatic pulse_reset(input int cycles, input logic [NL-1:0] li);
        #2;
        resetn = 1'b0;
        wr_en  = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({led_out, wr_ack, period_start} !== '0) begin
            n_bad++;
            $display("FAIL async_reset led_out=%h wr_ack=%b period_start=%b, required all 0",
                     led_out, wr_ack, period_start);
        end
        repeat (cycles) @(negedge clk);
        resetn = 1'b1;
        drive(li, 1'b0, '0, '0);
    endtask

    // Monitor: reset state while held, scoreboard entries otherwise
    always @(posedge clk) begin
        exp_t e;
        exp_t got;
        #1;
        got = {led_out, wr_ack, period_start};
        if (!resetn) begin
            n_cmp++;
            if (got !== '0) begin
                n_bad++;
                $display("FAIL reset_state led_out=%h wr_ack=%b period_start=%b, required all 0",
                         led_out, wr_ack, period_start);
            end
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL scoreboard @%0t got led=%h ack=%b ps=%b, expected led=%h ack=%b ps=%b",
                         $time, led_out, wr_ack, period_start, e.led, e.ack, e.ps);
            end
        end
    end

    function automatic logic [PB-1:0] rand_duty();
        case ($urandom_range(0, 5))
            0: return 8'd0;
            1: return 8'd255;
            2: return 8'd1;
            3: return 8'd254;
            4: return 8'd128;
            default: return PB'($urandom);
        endcase
    endfunction

    initial begin
        bit found;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset release with a fixed pattern: pass-through, first period_start
        resetn = 1'b1;
        drive(6'h25, 1'b0, '0, '0);
        idle(PERIOD + 10, 6'h25);

        // ch0 duty 64, ch3 duty 0 mid-period, all LEDs requested on
        step('1, 1'b1, 3'd0, 8'd64);
        idle(100, '1);
        step('1, 1'b1, 3'd3, 8'd0);
        idle(2 * PERIOD, '1);

        // Out-of-range channels are acked and dropped
        step('1, 1'b1, 3'd6, 8'd0);
        step('1, 1'b1, 3'd7, 8'd0);
        idle(PERIOD, '1);

        // Write in the exact wrap cycle: lands one period later
        found = 1'b0;
        for (int i = 0; i < PERIOD + 4; i++) begin
            step('1, 1'b0, '0, '0);
            if (period_start) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL period_start_wait got no pulse within %0d cycles, required one", PERIOD + 4);
        end
        idle(PERIOD - 2, '1);
        step('1, 1'b1, 3'd1, 8'd128);
        idle(2 * PERIOD + 5, '1);

        // Reset mid-period and mid-write with duty 32 active on ch0
        step('1, 1'b1, 3'd0, 8'd32);
        idle(PERIOD + 20, '1);
        step('1, 1'b1, 3'd2, 8'd5);
        pulse_reset(3, '1);
        idle(PERIOD + 50, '1);

        // Randomised traffic with one extra reset pulse
        for (int p = 0; p < 40; p++) begin
            for (int c = 0; c < PERIOD; c++) begin
                if ($urandom_range(0, 63) == 0)
                    step(NL'($urandom), 1'b1, AW'($urandom_range(0, 7)), rand_duty());
                else
                    step(NL'($urandom), 1'b0, '0, '0);
            end
            if (p == 20) pulse_reset($urandom_range(1, 4), NL'($urandom));
        end

        idle(2, '0);
        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending expectations, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
